// File: rtl/cuckoo_update_sched.sv
// cuckoo_update_sched: stalls the cuckoo lookup pipeline, drains it and issues host rule-table writes.
// Strobes and lk_enable are gated by rst_n so a write due at a reset edge never reaches the RAMs.
module cuckoo_update_sched #(
  parameter int DRAIN_CYCLES = 4,
  parameter int STARVE_MAX   = 64,
  parameter int BURST_MAX    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lk_req,
  output logic         lk_enable,
  output logic         upd_active,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_sel,
  input  logic [10:0]  cmd_addr,
  input  logic [113:0] cmd_data,
  output logic         idx_we,
  output logic [10:0]  idx_addr,
  output logic [8:0]   idx_din,
  output logic         ent_we,
  output logic [8:0]   ent_addr,
  output logic [113:0] ent_din,
  output logic         bad_addr,
  output logic [15:0]  wr_count
);
  typedef enum logic [1:0] {RUN, DRAIN, WRITE, SETTLE} state_t;
  localparam logic [7:0] STARVE_LAST = 8'(STARVE_MAX - 1);
  localparam logic [7:0] BURST_LAST  = 8'(BURST_MAX - 1);
  localparam logic [3:0] DRAIN_LAST  = 4'(DRAIN_CYCLES - 1);
  state_t         state_q, state_d;
  logic [7:0]     starve_q, starve_d, burst_q, burst_d;
  logic [3:0]     drain_q, drain_d;
  logic           upd_active_q, upd_active_d;
  logic           idx_we_q, idx_we_d, ent_we_q, ent_we_d;
  logic [10:0]    idx_addr_q, idx_addr_d;
  logic [8:0]     idx_din_q, idx_din_d, ent_addr_q, ent_addr_d;
  logic [113:0]   ent_din_q, ent_din_d;
  logic           bad_addr_q, bad_addr_d;
  logic [15:0]    wr_count_q, wr_count_d;
  logic           accept, ent_ok;
  always_comb begin
    accept   = cmd_valid && state_q == WRITE;
    ent_ok   = cmd_addr[10:9] == 2'b00;
    state_d  = state_q;
    starve_d = cmd_valid ? starve_q : 8'd0;
    drain_d  = drain_q;
    burst_d  = burst_q;
    case (state_q)
      RUN: begin
        starve_d = cmd_valid && lk_req ? starve_q + 8'd1 : starve_d;
        if (cmd_valid && (!lk_req || starve_q == STARVE_LAST)) begin
          state_d = DRAIN;
          drain_d = DRAIN_LAST;
        end
      end
      DRAIN: begin
        drain_d = drain_q - 4'd1;
        state_d = drain_q == 4'd0 ? WRITE : DRAIN;
      end
      WRITE: begin
        burst_d = burst_q + 8'(accept);
        state_d = !cmd_valid || burst_q == BURST_LAST ? SETTLE : WRITE;
      end
      SETTLE: begin
        state_d  = RUN;
        burst_d  = 8'd0;
        starve_d = 8'd0;
      end
    endcase
    upd_active_d = state_d != RUN;
    idx_we_d     = accept && !cmd_sel;
    ent_we_d     = accept && cmd_sel && ent_ok;
    idx_addr_d   = idx_we_d ? cmd_addr : idx_addr_q;
    idx_din_d    = idx_we_d ? cmd_data[8:0] : idx_din_q;
    ent_addr_d   = ent_we_d ? cmd_addr[8:0] : ent_addr_q;
    ent_din_d    = ent_we_d ? cmd_data : ent_din_q;
    bad_addr_d   = bad_addr_q || (accept && cmd_sel && !ent_ok);
    wr_count_d   = (idx_we_d || ent_we_d) && wr_count_q != 16'hFFFF ? wr_count_q + 16'd1 : wr_count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      starve_q     <= 8'd0;
      burst_q      <= 8'd0;
      drain_q      <= 4'd0;
      upd_active_q <= 1'b0;
      idx_we_q     <= 1'b0;
      ent_we_q     <= 1'b0;
      idx_addr_q   <= 11'd0;
      idx_din_q    <= 9'd0;
      ent_addr_q   <= 9'd0;
      ent_din_q    <= 114'd0;
      bad_addr_q   <= 1'b0;
      wr_count_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      burst_q      <= burst_d;
      drain_q      <= drain_d;
      upd_active_q <= upd_active_d;
      idx_we_q     <= idx_we_d;
      ent_we_q     <= ent_we_d;
      idx_addr_q   <= idx_addr_d;
      idx_din_q    <= idx_din_d;
      ent_addr_q   <= ent_addr_d;
      ent_din_q    <= ent_din_d;
      bad_addr_q   <= bad_addr_d;
      wr_count_q   <= wr_count_d;
    end
  end
  assign lk_enable  = rst_n && lk_req && state_q == RUN;
  assign cmd_ready  = state_q == WRITE;
  assign upd_active = upd_active_q;
  assign idx_we     = rst_n && idx_we_q;
  assign ent_we     = rst_n && ent_we_q;
  assign idx_addr   = idx_addr_q;
  assign idx_din    = idx_din_q;
  assign ent_addr   = ent_addr_q;
  assign ent_din    = ent_din_q;
  assign bad_addr   = bad_addr_q;
  assign wr_count   = wr_count_q;
endmodule

// File: tb/tb_cuckoo_update_sched.sv
// tb_cuckoo_update_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_cuckoo_update_sched;
  localparam int D = 4, S = 64, B = 8;
  logic         clk = 0, rst_n = 0, lk_req = 0, cmd_valid = 0, cmd_sel = 0;
  logic [10:0]  cmd_addr = '0;
  logic [113:0] cmd_data = '0;
  logic         lk_enable, upd_active, cmd_ready, idx_we, ent_we, bad_addr;
  logic [10:0]  idx_addr;
  logic [8:0]   idx_din, ent_addr;
  logic [113:0] ent_din;
  logic [15:0]  wr_count;
  int n_chk = 0, n_err = 0;
  cuckoo_update_sched #(.DRAIN_CYCLES(D), .STARVE_MAX(S), .BURST_MAX(B)) dut (
    .clk(clk), .rst_n(rst_n), .lk_req(lk_req), .lk_enable(lk_enable), .upd_active(upd_active),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .idx_we(idx_we), .idx_addr(idx_addr), .idx_din(idx_din),
    .ent_we(ent_we), .ent_addr(ent_addr), .ent_din(ent_din), .bad_addr(bad_addr),
    .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic logic [113:0] rnd114();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[113:0];
  endfunction
  // Holds the current command until cmd_ready, then returns just after the accepting edge
  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(cmd_ready), 128'(1));
    @(posedge clk);
    #1;
  endtask
  // Reference model: every accepted command predicts next-cycle strobe, count and sticky flag;
  // windows, starvation bound and lookup gating are checked from the rules directly.
  bit p_idx = 0, p_ent = 0, m_bad = 0, exp_upd = 0;
  logic [10:0]  e_ia;
  logic [8:0]   e_id, e_ea;
  logic [113:0] e_ed;
  int m_cnt = 0, win_len = 0, win_acc = 0, wait_n = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gate", 128'({idx_we, ent_we, lk_enable}), 128'(0));
      p_idx = 0; p_ent = 0; m_bad = 0; exp_upd = 0;
      m_cnt = 0; win_len = 0; win_acc = 0; wait_n = 0;
    end else begin
      chk("lk_en", 128'(lk_enable), 128'(lk_req & ~upd_active));
      chk("rdy_out_win", 128'(cmd_ready & ~upd_active), 128'(0));
      chk("idx_we", 128'(idx_we), 128'(p_idx));
      chk("ent_we", 128'(ent_we), 128'(p_ent));
      if (p_idx) begin
        chk("idx_addr", 128'(idx_addr), 128'(e_ia));
        chk("idx_din", 128'(idx_din), 128'(e_id));
      end
      if (p_ent) begin
        chk("ent_addr", 128'(ent_addr), 128'(e_ea));
        chk("ent_din", 128'(ent_din), 128'(e_ed));
      end
      chk("wr_count", 128'(wr_count), 128'(m_cnt));
      chk("bad_addr", 128'(bad_addr), 128'(m_bad));
      if (exp_upd) chk("go_upd", 128'(upd_active), 128'(1));
      if (upd_active) win_len++;
      else if (win_len != 0) begin
        chk("win_max", 128'(win_len <= D + B + 1), 128'(1));
        chk("win_min", 128'(win_len >= D + 2), 128'(1));
        chk("win_acc", 128'(win_acc <= B), 128'(1));
        win_len = 0;
        win_acc = 0;
      end
      p_idx = cmd_valid && cmd_ready && !cmd_sel;
      p_ent = cmd_valid && cmd_ready && cmd_sel && cmd_addr[10:9] == 2'b00;
      if (cmd_valid && cmd_ready) begin
        win_acc++;
        if (cmd_sel && cmd_addr[10:9] != 2'b00) m_bad = 1;
      end
      if (p_idx) begin e_ia = cmd_addr; e_id = cmd_data[8:0]; end
      if (p_ent) begin e_ea = cmd_addr[8:0]; e_ed = cmd_data; end
      if (p_idx || p_ent) m_cnt++;
      wait_n = (!upd_active && cmd_valid && lk_req) ? wait_n + 1 : 0;
      exp_upd = !upd_active && cmd_valid && (!lk_req || wait_n >= S);
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  int n, pq[$], lq[$];
  bit done = 0;
  initial begin
    lk_req = 1; cmd_valid = 1; cmd_sel = 0; cmd_addr = 11'h2A5; cmd_data = 114'h1F3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 128'({lk_enable, upd_active, cmd_ready, idx_we, ent_we, bad_addr}), 128'(0));
    chk("rst_cnt", 128'(wr_count), 128'(0));
    chk("rst_data", 128'({idx_addr, idx_din, ent_addr}), 128'(0));
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_lk", 128'(lk_enable), 128'(1));
      chk("post_rst_rdy", 128'(cmd_ready), 128'(0));
    end
    @(posedge clk); #1;
    lk_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_drain_rdy", 128'(cmd_ready), 128'(0));
    end
    @(negedge clk);
    chk("idle_rdy", 128'(cmd_ready), 128'(1));
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (idx_we) begin
        n++;
        chk("idle_addr", 128'(idx_addr), 128'(11'h2A5));
        chk("idle_din", 128'(idx_din), 128'(9'h1F3));
      end
    end
    chk("idle_pulses", 128'(n), 128'(1));
    chk("idle_cnt", 128'(wr_count), 128'(1));
    chk("idle_done", 128'(upd_active), 128'(0));
    lk_req = 1;
    repeat (2) @(posedge clk);
    #1;
    cmd_valid = 1; cmd_sel = 1; cmd_addr = 11'h005; cmd_data = rnd114();
    n = 0;
    repeat (S) begin
      @(negedge clk);
      n += int'(lk_enable);
    end
    chk("starve_hold", 128'(n), 128'(S));
    @(negedge clk);
    chk("starve_drop", 128'(lk_enable), 128'(0));
    wait_rdy("starve_acc");
    cmd_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (upd_active && n < 20);
    chk("starve_resume", 128'(lk_enable), 128'(1));
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          cmd_sel = 1; cmd_addr = 11'(i); cmd_data = rnd114(); cmd_valid = 1;
          wait_rdy("burst_acc");
        end
        cmd_valid = 0;
      end
      begin
        int t = 0, l = 0;
        repeat (260) begin
          @(negedge clk);
          t++;
          if (ent_we) begin
            pq.push_back(t);
            lq.push_back(l);
            l = 0;
          end else l += int'(lk_enable);
        end
      end
    join
    chk("burst_pulses", 128'(pq.size()), 128'(10));
    if (pq.size() == 10) begin
      chk("burst_run", 128'(pq[7] - pq[0]), 128'(7));
      chk("burst_gap_lk", 128'(lq[8]), 128'(S));
      chk("burst_gap", 128'(pq[8] - pq[7] >= S + D), 128'(1));
      chk("burst_tail", 128'(pq[9] - pq[8]), 128'(1));
    end
    lk_req = 0;
    chk("bad_pre_cnt", 128'(wr_count), 128'(12));
    cmd_sel = 1; cmd_addr = 11'h600; cmd_data = rnd114(); cmd_valid = 1;
    wait_rdy("bad_acc");
    cmd_valid = 0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(ent_we);
    end
    chk("bad_nowe", 128'(n), 128'(0));
    chk("bad_flag", 128'(bad_addr), 128'(1));
    chk("bad_cnt", 128'(wr_count), 128'(12));
    cmd_sel = 0; cmd_addr = 11'h011; cmd_data = 114'h0AA; cmd_valid = 1;
    wait_rdy("bad_next_acc");
    cmd_valid = 0;
    repeat (8) @(negedge clk);
    chk("bad_sticky", 128'(bad_addr), 128'(1));
    chk("bad_next_cnt", 128'(wr_count), 128'(13));
    @(posedge clk); #1;
    cmd_sel = 0; cmd_addr = 11'h3C3; cmd_data = 114'h155; cmd_valid = 1;
    wait_rdy("mid_acc");
    rst_n = 0;
    cmd_valid = 0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n += int'(idx_we | ent_we);
    end
    chk("mid_nowe", 128'(n), 128'(0));
    chk("mid_cnt", 128'(wr_count), 128'(0));
    chk("mid_state", 128'({upd_active, cmd_ready, bad_addr}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1;
    lk_req = 1;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n += int'(idx_we | ent_we);
    end
    chk("mid_after_nowe", 128'(n), 128'(0));
    chk("mid_run", 128'(lk_enable), 128'(1));
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          int g;
          g = $urandom_range(0, 3);
          if (g != 0) begin
            cmd_valid = 0;
            repeat (g) @(posedge clk);
            #1;
          end
          cmd_sel = 1'($urandom_range(0, 1));
          cmd_addr = {($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 9'($urandom())};
          cmd_data = rnd114();
          cmd_valid = 1;
          wait_rdy("rnd_acc");
        end
        cmd_valid = 0;
        done = 1;
      end
      begin
        int mode;
        mode = 1;
        while (!done) begin
          if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 2);
          lk_req = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 2);
          @(posedge clk);
          #1;
        end
      end
    join
    repeat (20) @(negedge clk);
    chk("rnd_idle", 128'(upd_active), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
